nx_stream_skid: RTL and testbench

Two-entry skid buffer on a node_message_t valid/ready stream. It registers the data and valid paths towards the consumer, and drives the producer's ready from a flop. This breaks every combinational path between the two sides. Placed between stream stages (router/node ports) to close timing without losing throughput.

---
 rtl/NXConstants.sv | 24 ++
 rtl/nx_stream_skid.sv | 56 +++++
 tb/tb_nx_stream_skid.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/NXConstants.sv
// Shared message definitions for the NX node network.
// node_message_t is the payload carried on every node stream.
package NXConstants;

    typedef enum logic [1:0] {
        CMD_LOAD_INSTR  = 2'd0,
        CMD_LOAD_OUTPUT = 2'd1,
        CMD_SIGNAL      = 2'd2,
        CMD_CONTROL     = 2'd3
    } node_command_t;

    typedef struct packed {
        logic [3:0]    row;
        logic [3:0]    column;
        node_command_t command;
        logic [5:0]    tag;
    } node_header_t;

    typedef struct packed {
        node_header_t header;
        logic [15:0]  payload;
    } node_message_t;

endpackage

// File: rtl/nx_stream_skid.sv
// Two-entry skid buffer on a node_message_t valid/ready stream.
// Every output, including the producer-facing ready, comes straight from a flop.
module nx_stream_skid
    import NXConstants::*;
(
    input  logic          i_clk,
    input  logic          i_rst,
    input  node_message_t i_inbound_data,
    input  logic          i_inbound_valid,
    output logic          o_inbound_ready,
    output node_message_t o_outbound_data,
    output logic          o_outbound_valid,
    input  logic          i_outbound_ready
);

    node_message_t out_data;
    logic          out_valid;
    node_message_t skid_data;
    logic          skid_valid;

    logic acc;
    logic free;

    assign acc  = i_inbound_valid & ~skid_valid;
    assign free = ~out_valid | i_outbound_ready;

    // A free primary always drains the skid first, which keeps strict FIFO order;
    // ready is low whenever the skid is occupied, so no input can race it.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (free) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (acc) begin
                out_data  <= i_inbound_data;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (acc) begin
            skid_data  <= i_inbound_data;
            skid_valid <= 1'b1;
        end
    end

    assign o_inbound_ready  = ~skid_valid;
    assign o_outbound_data  = out_data;
    assign o_outbound_valid = out_valid;

endmodule

// File: tb/tb_nx_stream_skid.sv
// Scoreboard bench for nx_stream_skid: accepted inputs are queued, delivered outputs popped and compared.
module tb_nx_stream_skid;
    import NXConstants::*;

    logic          i_clk = 1'b0;
    logic          i_rst;
    node_message_t i_inbound_data;
    logic          i_inbound_valid;
    logic          o_inbound_ready;
    node_message_t o_outbound_data;
    logic          o_outbound_valid;
    logic          i_outbound_ready;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          occ = 0;

    nx_stream_skid dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_inbound_data   (i_inbound_data),
        .i_inbound_valid  (i_inbound_valid),
        .o_inbound_ready  (o_inbound_ready),
        .o_outbound_data  (o_outbound_data),
        .o_outbound_valid (o_outbound_valid),
        .i_outbound_ready (i_outbound_ready)
    );

    always #5 i_clk = ~i_clk;

    // Called at a falling edge: drives inputs, samples outputs, advances the occupancy
    // model across one rising edge and returns at the next falling edge.
    task automatic drive(input logic v, input logic [31:0] d, input logic r,
                         output logic obs_rdy, output logic obs_vld, output logic [31:0] obs_data,
                         output logic exp_rdy, output logic exp_vld, output logic deq);
        i_inbound_valid  = v;
        i_inbound_data   = d;
        i_outbound_ready = r;
        #1;
        obs_rdy  = o_inbound_ready;
        obs_vld  = o_outbound_valid;
        obs_data = o_outbound_data;
        exp_rdy  = (occ < 2);
        exp_vld  = (occ > 0);
        deq      = exp_vld & r;
        if (v && exp_rdy) exp_q.push_back(d);
        occ = occ + ((v && exp_rdy) ? 1 : 0) - (deq ? 1 : 0);
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        logic rdy, vld, erdy, evld, deq;
        logic [31:0] dat;
        i_rst = 1'b0;
        i_inbound_valid = 1'b1;
        i_inbound_data = 32'hDEADBEEF;
        i_outbound_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++; if (o_outbound_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_outbound_valid); end
        checks++; if (o_outbound_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", o_outbound_data); end
        checks++; if (o_inbound_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", o_inbound_ready); end
        i_inbound_valid = 1'b0;
        i_rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 32'h0, 1'b1, rdy, vld, dat, erdy, evld, deq);
            checks++; if (vld !== 1'b0) begin errors++; $display("FAIL post_reset_valid cycle %0d got %b want 0", k, vld); end
        end
    endtask

    task automatic test_streaming();
        logic rdy, vld, erdy, evld, deq;
        logic [31:0] dat;
        logic [31:0] vals [3];
        vals[0] = 32'h11111111; vals[1] = 32'h22222222; vals[2] = 32'h33333333;
        for (int k = 0; k < 6; k++) begin
            drive(k < 3, (k < 3) ? vals[k] : 32'h0, 1'b1, rdy, vld, dat, erdy, evld, deq);
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL stream_ready cycle %0d got %b want 1", k, rdy); end
            checks++; if (vld !== (k >= 1 && k <= 3)) begin errors++; $display("FAIL stream_valid cycle %0d got %b want %b", k, vld, (k >= 1 && k <= 3)); end
            if (deq) begin
                checks++; if (dat !== exp_q[0]) begin errors++; $display("FAIL stream_data cycle %0d got %h want %h", k, dat, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_stall_fill();
        logic rdy, vld, erdy, evld, deq;
        logic [31:0] dat;
        logic [31:0] got[$];
        logic c_pending;
        drive(1'b1, 32'hAAAA0001, 1'b0, rdy, vld, dat, erdy, evld, deq);
        checks++; if (vld !== 1'b0) begin errors++; $display("FAIL stall_empty_valid got %b want 0", vld); end
        drive(1'b1, 32'hBBBB0002, 1'b0, rdy, vld, dat, erdy, evld, deq);
        checks++; if (vld !== 1'b1 || dat !== 32'hAAAA0001) begin errors++; $display("FAIL stall_hold_a got %b/%h want 1/aaaa0001", vld, dat); end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 32'hCCCC0003, 1'b0, rdy, vld, dat, erdy, evld, deq);
            checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL stall_full_ready cycle %0d got %b want 0", k, rdy); end
            checks++; if (vld !== 1'b1 || dat !== 32'hAAAA0001) begin errors++; $display("FAIL stall_stable_a cycle %0d got %b/%h want 1/aaaa0001", k, vld, dat); end
        end
        c_pending = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(c_pending, 32'hCCCC0003, 1'b1, rdy, vld, dat, erdy, evld, deq);
            if (c_pending && erdy) c_pending = 1'b0;
            checks++; if (rdy !== erdy) begin errors++; $display("FAIL release_ready cycle %0d got %b want %b", k, rdy, erdy); end
            if (deq) begin
                got.push_back(dat);
                checks++; if (vld !== 1'b1 || dat !== exp_q[0]) begin errors++; $display("FAIL release_data cycle %0d got %b/%h want 1/%h", k, vld, dat, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
        checks++;
        if (got.size() != 3 || got[0] !== 32'hAAAA0001 || got[1] !== 32'hBBBB0002 || got[2] !== 32'hCCCC0003) begin
            errors++; $display("FAIL release_order got %0d items want 3 (A,B,C)", got.size());
        end
    endtask

    task automatic test_bubble();
        logic rdy, vld, erdy, evld, deq;
        logic [31:0] dat;
        for (int k = 0; k < 5; k++) begin
            drive(k == 0, (k == 0) ? 32'h12345678 : 32'h0, 1'b1, rdy, vld, dat, erdy, evld, deq);
            checks++; if (vld !== (k == 1)) begin errors++; $display("FAIL bubble_valid cycle %0d got %b want %b", k, vld, (k == 1)); end
            if (deq) begin
                checks++; if (dat !== 32'h12345678) begin errors++; $display("FAIL bubble_data got %h want 12345678", dat); end
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_mid_reset();
        logic rdy, vld, erdy, evld, deq;
        logic [31:0] dat;
        drive(1'b1, 32'h0F0F0F0F, 1'b0, rdy, vld, dat, erdy, evld, deq);
        drive(1'b1, 32'hF0F0F0F0, 1'b0, rdy, vld, dat, erdy, evld, deq);
        i_inbound_valid = 1'b0;
        #1;
        checks++; if (o_inbound_ready !== 1'b0 || o_outbound_valid !== 1'b1) begin errors++; $display("FAIL midrst_full got rdy %b vld %b want 0/1", o_inbound_ready, o_outbound_valid); end
        i_rst = 1'b0;
        #1;
        checks++; if (o_outbound_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", o_outbound_valid); end
        checks++; if (o_outbound_data !== 32'h0) begin errors++; $display("FAIL midrst_data got %h want 0", o_outbound_data); end
        checks++; if (o_inbound_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", o_inbound_ready); end
        #1;
        i_rst = 1'b1;
        exp_q.delete();
        occ = 0;
        @(negedge i_clk);
        for (int k = 0; k < 4; k++) begin
            drive(k < 2, (k == 0) ? 32'h5A5A0001 : 32'h5A5A0002, 1'b1, rdy, vld, dat, erdy, evld, deq);
            checks++; if (vld !== evld) begin errors++; $display("FAIL midrst_after_valid cycle %0d got %b want %b", k, vld, evld); end
            if (deq) begin
                checks++; if (dat !== exp_q[0]) begin errors++; $display("FAIL midrst_after_data cycle %0d got %h want %h", k, dat, exp_q[0]); end
                void'(exp_q.pop_front());
            end
        end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL midrst_drain got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_random();
        logic rdy, vld, erdy, evld, deq, rb;
        logic [31:0] dat;
        logic prev_stall;
        logic [31:0] prev_data;
        int delivered;
        delivered = 0;
        prev_stall = 1'b0;
        prev_data = 32'h0;
        for (int k = 0; k < 10000; k++) begin
            logic v, r;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) != 0);
            rb = o_inbound_ready;
            i_outbound_ready = ~i_outbound_ready;
            #1;
            checks++; if (o_inbound_ready !== rb) begin errors++; $display("FAIL rand_ready_comb cycle %0d got %b want %b", k, o_inbound_ready, rb); end
            drive(v, $urandom, r, rdy, vld, dat, erdy, evld, deq);
            checks++; if (rdy !== erdy || vld !== evld) begin errors++; $display("FAIL rand_flags cycle %0d got %b/%b want %b/%b", k, rdy, vld, erdy, evld); end
            if (prev_stall) begin
                checks++; if (vld !== 1'b1 || dat !== prev_data) begin errors++; $display("FAIL rand_stable cycle %0d got %b/%h want 1/%h", k, vld, dat, prev_data); end
            end
            if (deq) begin
                checks++; if (exp_q.size() == 0 || dat !== exp_q[0]) begin errors++; $display("FAIL rand_data cycle %0d got %h want %h", k, dat, (exp_q.size() != 0) ? exp_q[0] : 32'hx); end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                delivered++;
            end
            prev_stall = vld & ~r;
            prev_data = dat;
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 1'b1, rdy, vld, dat, erdy, evld, deq);
            if (deq) begin
                checks++; if (dat !== exp_q[0]) begin errors++; $display("FAIL rand_drain_data got %h want %h", dat, exp_q[0]); end
                void'(exp_q.pop_front());
                delivered++;
            end
        end
        checks++; if (exp_q.size() != 0 || o_outbound_valid !== 1'b0) begin errors++; $display("FAIL rand_lossless left %0d valid %b want 0/0", exp_q.size(), o_outbound_valid); end
        checks++; if (delivered == 0) begin errors++; $display("FAIL rand_activity delivered %0d want >0", delivered); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_fill();
        test_bubble();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
